vga_timing_ctrl: RTL and testbench
==================================

# vga_timing_ctrl

Frame-level sequencer for the VGA horizontal/vertical timing datapath. Derives the pixel-rate tick from the 50 MHz system clock, steps the horizontal counter and the vertical counter it carries into, decodes HSync/VSync/VideoOn, and starts and stops scanning cleanly on frame boundaries under an enable handshake. It sits between the top-level control and the pixel generator, which consumes the counters, `VideoOn` and `PixelTick`.

## Interface
- `CLK_DIV`, 2: system clocks per pixel; 50 MHz / 2 = 25 MHz pixel rate; legal range 1..16.
- `H_VISIBLE`, 640 / `H_FRONT`, 16 / `H_SYNC`, 96 / `H_BACK`, 48: horizontal segments in pixels; total 800.
- `V_VISIBLE`, 480 / `V_FRONT`, 10 / `V_SYNC`, 2 / `V_BACK`, 33: vertical segments in lines; total 525.
- `Clk`  in  1  system clock, 50 MHz.
- `Reset`  in  1  asynchronous, active-low reset.
- `Enable`  in  1  level request to scan; sampled every clock.
- `cntHorizontal`  out  11  current pixel column, 0..H_TOTAL-1.
- `cntVertical`  out  11  current line, 0..V_TOTAL-1.
- `PixelTick`  out  1  one-clock strobe; counters advance on the clock edge where it is high.
- `HSync`  out  1  active-low horizontal sync.
- `VSync`  out  1  active-low vertical sync.
- `VideoOn`  out  1  high while in the visible region and RUN/STOPPING.
- `FrameStart`  out  1  one-clock pulse when counters wrap to (0,0).
- `Busy`  out  1  high in any state except IDLE.

## Operation
- States: IDLE, RUN, STOPPING.
- IDLE: prescaler, both counters held at 0; HSync=VSync=1, VideoOn=0, PixelTick=0. Enable=1 -> RUN on the next edge.
- RUN: prescaler counts 0..CLK_DIV-1; PixelTick=1 when prescaler==CLK_DIV-1. On tick, h increments; at h==H_TOTAL-1 it wraps to 0 and v increments; at v==V_TOTAL-1 with h wrap, v wraps to 0 and FrameStart pulses on that same edge (registered, visible the following clock). Enable=0 -> STOPPING.
- STOPPING: counting continues unchanged. Enable=1 -> RUN (cancel, no disturbance). On the tick that wraps (H_TOTAL-1, V_TOTAL-1) -> IDLE, no FrameStart.
- Decode (combinational from counter registers, state != IDLE): HSync=0 for h in [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC-1] = [656,751]; VSync=0 for v in [490,491]; VideoOn = h<H_VISIBLE && v<V_VISIBLE.
- All counter arithmetic unsigned, 11 bits; totals must be ≤2047.

## Timing
- Reset values: state IDLE, counters 0, prescaler 0, PixelTick 0, FrameStart 0, Busy 0, HSync 1, VSync 1, VideoOn 0.
- Enable rises at edge N -> Busy=1 after edge N+1; first PixelTick CLK_DIV clocks after entering RUN; VideoOn=1 from entry into RUN (position 0,0).
- CLK_DIV=1: PixelTick held high continuously in RUN/STOPPING.
- Decoded outputs have zero latency relative to counter registers.
- Reset asserted mid-frame: immediate return to reset values regardless of state.
- A full frame is 800×525×CLK_DIV = 840 000 clocks at defaults.

## Configuration
- `VGA_FRAME_COUNT_EN`: defined -> adds output `FrameCount` (16 bits), reset 0, increments on each FrameStart, wraps at 65535->0, cleared on entry to IDLE. Undefined -> port and counter absent; all other behaviour identical.

## Structure
- Shared package `vga_timing_pkg`: default segment constants for 640×480@60, derived H_TOTAL/V_TOTAL, sync polarity constant, state encoding.
- One sub-module: `vga_pixel_prescaler` (prescaler + PixelTick generation, held clear by an input from the FSM).
- FSM, counters and decode live in `vga_timing_ctrl`.

## Test plan
- Reset held 100 ns, Enable=0 -> all outputs at reset values, Busy=0, counters 0 for 1000 clocks.
- Enable=1 with defaults -> PixelTick every 2nd clock; HSync low exactly for h=656..751 (96 ticks); h wraps 799->0 and v increments by 1.
- Run one full frame -> VSync low for v=490..491 only; FrameStart pulses once after 840 000 clocks; VideoOn high for exactly 640×480 ticks per frame.
- Drop Enable at h=100, v=200 -> Busy stays 1, scanning continues to (799,524), then IDLE with counters 0, no FrameStart; re-raise Enable mid-STOPPING -> stays RUN, counters undisturbed.
- Assert Reset at h=700 (inside HSync) -> HSync=1, counters 0, Busy=0 immediately, without waiting for a clock.
- `VGA_FRAME_COUNT_EN` defined, CLK_DIV=1, small segments (8/2/2/2 × 4/1/1/1) -> FrameCount reaches 3 after three frames of 14×7 clocks each.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: shared constants and FSM encoding for the VGA timing controller.
// Latency: n/a (constants and types only). Backpressure: n/a.
// Contents: 640x480@60 segment defaults, derived totals, sync polarity, state type.
package vga_timing_pkg;

   // Counter width; horizontal and vertical totals must both fit (<= 2047).
   localparam int CNT_W = 11;

   localparam int H_VISIBLE_DEF = 640;
   localparam int H_FRONT_DEF   = 16;
   localparam int H_SYNC_DEF    = 96;
   localparam int H_BACK_DEF    = 48;
   localparam int H_TOTAL_DEF   = H_VISIBLE_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;

   localparam int V_VISIBLE_DEF = 480;
   localparam int V_FRONT_DEF   = 10;
   localparam int V_SYNC_DEF    = 2;
   localparam int V_BACK_DEF    = 33;
   localparam int V_TOTAL_DEF   = V_VISIBLE_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;

   // Both syncs are active-low for 640x480@60.
   localparam logic SYNC_ACTIVE = 1'b0;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_RUN      = 2'd1,
      ST_STOPPING = 2'd2
   } state_t;

endpackage

// File: rtl/vga_pixel_prescaler.sv
// vga_pixel_prescaler: divides the system clock down to a one-clock pixel strobe.
// Latency: tick is decoded from the prescaler register, first tick CLK_DIV clocks after clear drops.
// Backpressure: none; clear holds the count at 0 and forces tick low.
// Ports: clk, rst_n (async active-low), clear (hold in reset state), tick (pixel strobe).
module vga_pixel_prescaler
   import vga_timing_pkg::*;
#(
   parameter int CLK_DIV = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   output logic tick
);

   // A 1-bit counter is kept for CLK_DIV == 1; it never leaves 0, so tick is simply !clear.
   localparam int            PW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [PW-1:0] LAST = PW'(CLK_DIV - 1);

   logic [PW-1:0] count;

   assign tick = !clear && (count == LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (clear || (count == LAST)) begin
         count <= '0;
      end else begin
         count <= count + PW'(1);
      end
   end

endmodule

// File: rtl/vga_timing_ctrl.sv
// vga_timing_ctrl: VGA frame sequencer - pixel tick, h/v counters, sync/video decode, enable handshake.
// Latency: Busy one clock after Enable; decoded syncs/VideoOn zero latency from counters; FrameStart registered.
// Backpressure: none; dropping Enable finishes the current frame before returning to IDLE.
// Ports: Clk, Reset (async active-low), Enable in; cntHorizontal/cntVertical, PixelTick, HSync, VSync,
//        VideoOn, FrameStart, Busy out; FrameCount (16b) out only when VGA_FRAME_COUNT_EN is defined.
module vga_timing_ctrl
   import vga_timing_pkg::*;
#(
   parameter int CLK_DIV   = 2,
   parameter int H_VISIBLE = H_VISIBLE_DEF,
   parameter int H_FRONT   = H_FRONT_DEF,
   parameter int H_SYNC    = H_SYNC_DEF,
   parameter int H_BACK    = H_BACK_DEF,
   parameter int V_VISIBLE = V_VISIBLE_DEF,
   parameter int V_FRONT   = V_FRONT_DEF,
   parameter int V_SYNC    = V_SYNC_DEF,
   parameter int V_BACK    = V_BACK_DEF
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             Enable,
   output logic [CNT_W-1:0] cntHorizontal,
   output logic [CNT_W-1:0] cntVertical,
   output logic             PixelTick,
   output logic             HSync,
   output logic             VSync,
   output logic             VideoOn,
   output logic             FrameStart,
   output logic             Busy
`ifdef VGA_FRAME_COUNT_EN
   ,
   output logic [15:0]      FrameCount
`endif
);

   localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

   localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
   localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
   localparam logic [CNT_W-1:0] H_VIS    = CNT_W'(H_VISIBLE);
   localparam logic [CNT_W-1:0] V_VIS    = CNT_W'(V_VISIBLE);
   localparam logic [CNT_W-1:0] HS_FIRST = CNT_W'(H_VISIBLE + H_FRONT);
   localparam logic [CNT_W-1:0] HS_LAST  = CNT_W'(H_VISIBLE + H_FRONT + H_SYNC - 1);
   localparam logic [CNT_W-1:0] VS_FIRST = CNT_W'(V_VISIBLE + V_FRONT);
   localparam logic [CNT_W-1:0] VS_LAST  = CNT_W'(V_VISIBLE + V_FRONT + V_SYNC - 1);

   state_t           state, state_nxt;
   logic [CNT_W-1:0] h_cnt, v_cnt;
   logic             active, frame_wrap, frame_start_nxt;
   logic             in_hsync, in_vsync;

   assign active = (state != ST_IDLE);

   vga_pixel_prescaler #(
      .CLK_DIV (CLK_DIV)
   ) u_prescaler (
      .clk   (Clk),
      .rst_n (Reset),
      .clear (!active),
      .tick  (PixelTick)
   );

   // The last pixel of the last line: the only point where scanning may stop.
   assign frame_wrap = PixelTick && (h_cnt == H_LAST) && (v_cnt == V_LAST);

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // FrameStart fires on every wrap that keeps scanning; the stop wrap into IDLE is silent.
   always_comb begin
      state_nxt       = state;
      frame_start_nxt = 1'b0;
      case (state)
         ST_IDLE: begin
            if (Enable) state_nxt = ST_RUN;
         end
         ST_RUN: begin
            frame_start_nxt = frame_wrap;
            if (!Enable) state_nxt = ST_STOPPING;
         end
         ST_STOPPING: begin
            if (Enable) begin
               state_nxt       = ST_RUN;
               frame_start_nxt = frame_wrap;
            end else if (frame_wrap) begin
               state_nxt = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         h_cnt      <= '0;
         v_cnt      <= '0;
         FrameStart <= 1'b0;
      end else begin
         FrameStart <= frame_start_nxt;
         if (!active) begin
            h_cnt <= '0;
            v_cnt <= '0;
         end else if (PixelTick) begin
            if (h_cnt == H_LAST) begin
               h_cnt <= '0;
               v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + CNT_W'(1);
            end else begin
               h_cnt <= h_cnt + CNT_W'(1);
            end
         end
      end
   end

`ifdef VGA_FRAME_COUNT_EN
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         FrameCount <= '0;
      end else if (state_nxt == ST_IDLE) begin
         FrameCount <= '0;
      end else if (frame_start_nxt) begin
         FrameCount <= FrameCount + 16'd1;
      end
   end
`endif

   assign in_hsync = (h_cnt >= HS_FIRST) && (h_cnt <= HS_LAST);
   assign in_vsync = (v_cnt >= VS_FIRST) && (v_cnt <= VS_LAST);

   assign cntHorizontal = h_cnt;
   assign cntVertical   = v_cnt;
   assign Busy          = active;
   assign HSync         = (active && in_hsync) ? SYNC_ACTIVE : !SYNC_ACTIVE;
   assign VSync         = (active && in_vsync) ? SYNC_ACTIVE : !SYNC_ACTIVE;
   assign VideoOn       = active && (h_cnt < H_VIS) && (v_cnt < V_VIS);

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// tb_vga_timing_ctrl: randomized scoreboard bench for vga_timing_ctrl (two instances, CLK_DIV 2 and 1).
// Small raster (8/2/2/2 x 4/1/1/1) so whole frames, stops and restarts fit in a short run.
// Reference model tracks clocks-since-frame-start and derives position and decode arithmetically.
module tb_vga_timing_ctrl;

   localparam int DIV0 = 2;
   localparam int DIV1 = 1;
   localparam int HV = 8, HF = 2, HS = 2, HB = 2;
   localparam int VV = 4, VF = 1, VS = 1, VB = 1;
   localparam int HT = HV + HF + HS + HB;
   localparam int VT = VV + VF + VS + VB;
   localparam int M_IDLE = 0, M_RUN = 1, M_STOP = 2;

   typedef struct packed {
      logic [10:0] h;
      logic [10:0] v;
      logic [5:0]  flags;   // {tick, hsync, vsync, video_on, frame_start, busy}
      logic [15:0] fc;
   } exp_t;

   typedef struct packed {
      exp_t e0;
      exp_t e1;
   } pair_t;

   logic        clk;
   logic        Reset;
   logic        Enable;
   logic [10:0] h_o [2];
   logic [10:0] v_o [2];
   logic        tick_o [2];
   logic        hs_o [2];
   logic        vs_o [2];
   logic        von_o [2];
   logic        fs_o [2];
   logic        busy_o [2];
`ifdef VGA_FRAME_COUNT_EN
   logic [15:0] fc_o [2];
`endif

   int    n_checks = 0;
   int    n_pass   = 0;
   pair_t exp_q[$];

   int   mode_m [2];
   int   t_m [2];
   logic fs_m [2];
   int   fc_m [2];

   vga_timing_ctrl #(
      .CLK_DIV(DIV0), .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
      .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
   ) u_dut0 (
      .Clk(clk), .Reset(Reset), .Enable(Enable),
      .cntHorizontal(h_o[0]), .cntVertical(v_o[0]), .PixelTick(tick_o[0]),
      .HSync(hs_o[0]), .VSync(vs_o[0]), .VideoOn(von_o[0]),
      .FrameStart(fs_o[0]), .Busy(busy_o[0])
`ifdef VGA_FRAME_COUNT_EN
      , .FrameCount(fc_o[0])
`endif
   );

   vga_timing_ctrl #(
      .CLK_DIV(DIV1), .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
      .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
   ) u_dut1 (
      .Clk(clk), .Reset(Reset), .Enable(Enable),
      .cntHorizontal(h_o[1]), .cntVertical(v_o[1]), .PixelTick(tick_o[1]),
      .HSync(hs_o[1]), .VSync(vs_o[1]), .VideoOn(von_o[1]),
      .FrameStart(fs_o[1]), .Busy(busy_o[1])
`ifdef VGA_FRAME_COUNT_EN
      , .FrameCount(fc_o[1])
`endif
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   task automatic check(input string name, input int k, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s dut%0d @%0t: got %0d, expected %0d", name, k, $time, act, exp);
   endtask

   function automatic int dv(input int k);
      return (k == 0) ? DIV0 : DIV1;
   endfunction

   // One clock edge of the reference: a frame is dv*HT*VT clocks, t counts clocks into it.
   function automatic void mstep(input int k, input logic en, input logic rn);
      logic last, to_idle;
      if (!rn) begin
         mode_m[k] = M_IDLE; t_m[k] = 0; fs_m[k] = 1'b0; fc_m[k] = 0;
         return;
      end
      fs_m[k] = 1'b0;
      if (mode_m[k] == M_IDLE) begin
         if (en) mode_m[k] = M_RUN;
         return;
      end
      last    = (t_m[k] == dv(k) * HT * VT - 1);
      to_idle = (mode_m[k] == M_STOP) && !en && last;
      t_m[k]  = last ? 0 : t_m[k] + 1;
      if (to_idle) begin
         mode_m[k] = M_IDLE;
         fc_m[k]   = 0;
      end else begin
         if (last) begin
            fs_m[k] = 1'b1;
            fc_m[k] = (fc_m[k] + 1) % 65536;
         end
         mode_m[k] = en ? M_RUN : M_STOP;
      end
   endfunction

   function automatic exp_t exp_of(input int k);
      exp_t e;
      int   h, v;
      logic act;
      act     = (mode_m[k] != M_IDLE);
      h       = (t_m[k] / dv(k)) % HT;
      v       = t_m[k] / (dv(k) * HT);
      e.h     = 11'(h);
      e.v     = 11'(v);
      e.flags = {act && (t_m[k] % dv(k) == dv(k) - 1),
                 !(act && h >= HV + HF && h < HV + HF + HS),
                 !(act && v >= VV + VF && v < VV + VF + VS),
                 act && h < HV && v < VV,
                 fs_m[k],
                 act};
      e.fc    = 16'(fc_m[k]);
      return e;
   endfunction

   task automatic cycle(input logic e);
      pair_t p;
      Enable = e;
      @(posedge clk);
      mstep(0, Enable, Reset);
      mstep(1, Enable, Reset);
      p.e0 = exp_of(0);
      p.e1 = exp_of(1);
      exp_q.push_back(p);
      #1;
   endtask

   task automatic cmp(input int k, input exp_t e);
      check("h_count", k, int'(h_o[k]), int'(e.h));
      check("v_count", k, int'(v_o[k]), int'(e.v));
      check("flags", k, int'({tick_o[k], hs_o[k], vs_o[k], von_o[k], fs_o[k], busy_o[k]}), int'(e.flags));
`ifdef VGA_FRAME_COUNT_EN
      check("frame_count", k, int'(fc_o[k]), int'(e.fc));
`endif
   endtask

   // Monitor: pops one expectation per clock, plus per-frame aggregate counts on dut0.
   initial begin
      pair_t p;
      int    von_cnt, hs_cnt, vs_cnt;
      bit    seen;
      von_cnt = 0; hs_cnt = 0; vs_cnt = 0; seen = 1'b0;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            p = exp_q.pop_front();
            cmp(0, p.e0);
            cmp(1, p.e1);
         end
         if (!busy_o[0]) begin
            seen = 1'b0;
         end else begin
            if (fs_o[0]) begin
               if (seen) begin
                  check("frame_video_ticks", 0, von_cnt, HV * VV);
                  check("frame_hsync_ticks", 0, hs_cnt, HS * VT);
                  check("frame_vsync_ticks", 0, vs_cnt, VS * HT);
               end
               seen = 1'b1; von_cnt = 0; hs_cnt = 0; vs_cnt = 0;
            end
            if (tick_o[0]) begin
               von_cnt += int'(von_o[0]);
               hs_cnt  += int'(!hs_o[0]);
               vs_cnt  += int'(!vs_o[0]);
            end
         end
      end
   end

   initial begin
      logic en;
      exp_t e;
      int   found;
      for (int k = 0; k < 2; k++) mstep(k, 1'b0, 1'b0);
      Enable = 1'b0;
      Reset  = 1'b1;
      #2 Reset = 1'b0;
      repeat (5) cycle(1'b0);
      Reset = 1'b1;

      // Idle with reset released, then continuous scanning.
      repeat (200) cycle(1'b0);
      repeat (600) cycle(1'b1);

      // Drop Enable mid-frame, cancel during STOPPING, then let both instances stop.
      found = 0;
      for (int i = 0; i < 400 && found == 0; i++) begin
         cycle(1'b1);
         e = exp_of(0);
         if (e.h == 11'd5 && e.v == 11'd2) found = 1;
      end
      check("reach_stop_point", 0, found, 1);
      repeat (100) cycle(1'b0);
      repeat (20) cycle(1'b1);
      repeat (400) cycle(1'b0);

      // Random Enable with long dwell times.
      en = 1'b0;
      repeat (4000) begin
         if ($urandom_range(0, 39) == 0) en = ~en;
         cycle(en);
      end

      // Asynchronous reset while dut0 sits inside HSync.
      found = 0;
      for (int i = 0; i < 500 && found == 0; i++) begin
         cycle(1'b1);
         e = exp_of(0);
         if (e.h == 11'(HV + HF + 1) && e.flags[0]) found = 1;
      end
      check("reach_hsync", 0, found, 1);
      check("pre_reset_hsync", 0, int'(hs_o[0]), 0);
      #11 Reset = 1'b0;
      #1;
      for (int k = 0; k < 2; k++) begin
         check("async_rst_h", k, int'(h_o[k]), 0);
         check("async_rst_v", k, int'(v_o[k]), 0);
         check("async_rst_flags", k,
               int'({tick_o[k], hs_o[k], vs_o[k], von_o[k], fs_o[k], busy_o[k]}), 6'b011000);
      end
      cycle(1'b1);
      Reset = 1'b1;
      repeat (300) cycle(1'b1);
      repeat (10) cycle(1'b0);

      @(negedge clk);
      #1;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
